// File: rtl/game_fsm_pkg.sv
// Shared definitions for the game controller: the state encoding, the width
// of the score and the score ceiling, plus a saturating increment helper.
package game_fsm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_OVER   = 2'd2;

    localparam int SCORE_W = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge detector with an optional 2-flop synchronizer in front of it.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset, clears every flop
//   d_i     input level (asynchronous when SYNC_EN=1)
//   rise_o  1-cycle pulse when the (synchronized) level goes 0 -> 1
//
// With SYNC_EN=0 the pulse is combinational from d_i so that a sample high at
// edge N is acted on at edge N by the consumer.
module sync_edge_detect #(
    parameter bit SYNC_EN = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic level;
    logic prev_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], d_i};
                end
            end
            assign level = sync_q[1];
        end else begin : g_nosync
            assign level = d_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;

endmodule

// File: rtl/game_fsm_ctrl.sv
// Game controller: sequences IDLE -> ACTIVE -> OVER and counts score edges
// while a round is active.
//
// Ports:
//   clkIn          100 MHz system clock
//   reset          synchronous active-high reset
//   incrementClk   slow game tick, asynchronous (internal timer only)
//   startGame      start / restart request
//   player_scored  score event, rising edge = one point
//   timer_expired  external end-of-round request (level)
//   game_active    registered, 1 only in ACTIVE
//   score          registered, points of the current / most recent round
//
// Build option: GAME_FSM_INTERNAL_TIMER_EN adds a round countdown of
// game_timer incrementClk ticks that ends the round on its own.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | after reset, waiting for startGame
// ST_ACTIVE | round running, score edges counted
// ST_OVER   | round ended, score frozen, waiting for startGame
// (3)       | illegal, recovers to ST_IDLE on the next edge
module game_fsm_ctrl
    import game_fsm_pkg::*;
#(
    parameter int unsigned game_timer = 30
) (
    input  logic               clkIn,
    input  logic               reset,
    input  logic               incrementClk,
    input  logic               startGame,
    input  logic               player_scored,
    input  logic               timer_expired,
    output logic               game_active,
    output logic [SCORE_W-1:0] score
);

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               game_active_q;
    logic               score_rise;
    logic               round_end;
    logic               enter_active;

    // The edge register runs in every state, so a level already high when
    // the round starts is not counted.
    sync_edge_detect #(.SYNC_EN(1'b0)) u_score_edge (
        .clk_i  (clkIn),
        .rst_i  (reset),
        .d_i    (player_scored),
        .rise_o (score_rise)
    );

`ifdef GAME_FSM_INTERNAL_TIMER_EN
    localparam int CNT_W = $clog2(game_timer + 1);

    logic             tick;
    logic             timer_done;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_edge_detect #(.SYNC_EN(1'b1)) u_tick (
        .clk_i  (clkIn),
        .rst_i  (reset),
        .d_i    (incrementClk),
        .rise_o (tick)
    );

    // The tick that takes the count from 1 to 0 ends the round in that cycle.
    assign timer_done = (state_q == ST_ACTIVE) && tick && (cnt_q == CNT_W'(1));
    assign round_end  = timer_expired | timer_done;

    always_comb begin
        cnt_d = cnt_q;
        if (enter_active) begin
            cnt_d = CNT_W'(game_timer);
        end else if ((state_q == ST_ACTIVE) && tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timer_in;
    assign unused_timer_in = incrementClk ^ (game_timer == 0);
    assign round_end       = timer_expired;
`endif

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (startGame) begin
                    state_d = ST_ACTIVE;
                    score_d = '0;
                end
            end
            ST_ACTIVE: begin
                // Expiry wins over a coincident score edge.
                if (round_end) begin
                    state_d = ST_OVER;
                end else if (score_rise) begin
                    score_d = sat_inc(score_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_active = (state_q != ST_ACTIVE) && (state_d == ST_ACTIVE);

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            score_q       <= '0;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            game_active_q <= (state_d == ST_ACTIVE);
        end
    end

    assign game_active = game_active_q;
    assign score       = score_q;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
module tb_game_fsm_ctrl;

    logic       clkIn;
    logic       reset;
    logic       incrementClk;
    logic       startGame;
    logic       player_scored;
    logic       timer_expired;
    logic       game_active;
    logic [5:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    game_fsm_ctrl #(.game_timer(3)) dut (
        .clkIn         (clkIn),
        .reset         (reset),
        .incrementClk  (incrementClk),
        .startGame     (startGame),
        .player_scored (player_scored),
        .timer_expired (timer_expired),
        .game_active   (game_active),
        .score         (score)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    // Reference model: phase of the game, point tally, last player_scored sample.
    typedef enum {P_WAIT, P_PLAY, P_DONE} phase_t;
    phase_t m_phase = P_WAIT;
    int     m_score = 0;
    bit     m_prev  = 1'b0;

    function automatic void model_step();
        bit rise;
        if (reset) begin
            m_phase = P_WAIT;
            m_score = 0;
            m_prev  = 1'b0;
        end else begin
            rise = player_scored && !m_prev;
            if (m_phase == P_PLAY) begin
                if (timer_expired) m_phase = P_DONE;
                else if (rise && m_score < 63) m_score = m_score + 1;
            end else if (startGame) begin
                m_phase = P_PLAY;
                m_score = 0;
            end
            m_prev = player_scored;
        end
    endfunction

    // Advance one clock: the model consumes the inputs the DUT samples at this edge.
    task automatic tick();
        model_step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic pulse_score();
        player_scored = 1'b1;
        tick();
        player_scored = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; incrementClk = 1'b0; startGame = 1'b0;
        player_scored = 1'b0; timer_expired = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (game_active !== 1'b0) begin
            $display("FAIL reset_active: got %b want 0", game_active); n_fail++;
        end
        n_checks++;
        if (score !== 6'd0) begin
            $display("FAIL reset_score: got %0d want 0", score); n_fail++;
        end
        pulse_score();
        n_checks++;
        if (score !== 6'd0 || game_active !== 1'b0) begin
            $display("FAIL idle_ignores_score: got score=%0d active=%b want 0/0", score, game_active); n_fail++;
        end
    endtask

    task automatic test_start_score();
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        n_checks++;
        if (game_active !== 1'b1 || score !== 6'd0) begin
            $display("FAIL start: got active=%b score=%0d want 1/0", game_active, score); n_fail++;
        end
        player_scored = 1'b1;
        tick();
        player_scored = 1'b0;
        n_checks++;
        if (score !== 6'd1) begin
            $display("FAIL score_latency: got %0d want 1", score); n_fail++;
        end
        repeat (9) tick();
        player_scored = 1'b1;
        tick();
        player_scored = 1'b0;
        tick();
        n_checks++;
        if (score !== 6'd2) begin
            $display("FAIL two_pulses: got %0d want 2", score); n_fail++;
        end
    endtask

    task automatic test_expiry();
        timer_expired = 1'b1;
        tick();
        timer_expired = 1'b0;
        n_checks++;
        if (game_active !== 1'b0 || score !== 6'd2) begin
            $display("FAIL expiry: got active=%b score=%0d want 0/2", game_active, score); n_fail++;
        end
        pulse_score();
        n_checks++;
        if (score !== 6'd2) begin
            $display("FAIL over_holds: got %0d want 2", score); n_fail++;
        end
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        n_checks++;
        if (game_active !== 1'b1 || score !== 6'd0) begin
            $display("FAIL restart: got active=%b score=%0d want 1/0", game_active, score); n_fail++;
        end
        player_scored = 1'b1;
        repeat (5) tick();
        player_scored = 1'b0;
        tick();
        n_checks++;
        if (score !== 6'd1) begin
            $display("FAIL held_level: got %0d want 1", score); n_fail++;
        end
    endtask

    task automatic test_saturation_collision();
        repeat (70) pulse_score();
        n_checks++;
        if (score !== 6'd63 || game_active !== 1'b1) begin
            $display("FAIL saturation: got score=%0d active=%b want 63/1", score, game_active); n_fail++;
        end
        timer_expired = 1'b1; tick(); timer_expired = 1'b0;
        startGame = 1'b1; tick(); startGame = 1'b0;
        repeat (3) pulse_score();
        player_scored = 1'b1;
        timer_expired = 1'b1;
        tick();
        player_scored = 1'b0;
        timer_expired = 1'b0;
        n_checks++;
        if (game_active !== 1'b0 || score !== 6'd3) begin
            $display("FAIL collision: got active=%b score=%0d want 0/3", game_active, score); n_fail++;
        end
        startGame = 1'b1;
        tick();
        n_checks++;
        if (game_active !== 1'b1 || score !== 6'd0) begin
            $display("FAIL ignore_start_active: got active=%b score=%0d want 1/0", game_active, score); n_fail++;
        end
        tick();
        startGame = 1'b0;
        n_checks++;
        if (game_active !== 1'b1) begin
            $display("FAIL start_held_active: got %b want 1", game_active); n_fail++;
        end
    endtask

    task automatic test_reset_mid_round();
        repeat (5) pulse_score();
        n_checks++;
        if (score !== 6'd5) begin
            $display("FAIL mid_round_score: got %0d want 5", score); n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (game_active !== 1'b0 || score !== 6'd0) begin
            $display("FAIL reset_mid_round: got active=%b score=%0d want 0/0", game_active, score); n_fail++;
        end
    endtask

`ifdef GAME_FSM_INTERNAL_TIMER_EN
    task automatic test_internal_timer();
        reset = 1'b1; tick(); reset = 1'b0;
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            incrementClk = 1'b1;
            if (r < 3) begin
                repeat (10) tick();
                incrementClk = 1'b0;
                repeat (10) tick();
                n_checks++;
                if (game_active !== 1'b1) begin
                    $display("FAIL timer_early_%0d: got %b want 1", r, game_active); n_fail++;
                end
            end else begin
                tick(); tick();
                n_checks++;
                if (game_active !== 1'b1) begin
                    $display("FAIL timer_pre_expiry: got %b want 1", game_active); n_fail++;
                end
                tick();
                n_checks++;
                if (game_active !== 1'b0) begin
                    $display("FAIL timer_expiry: got %b want 0", game_active); n_fail++;
                end
            end
        end
        incrementClk = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
    endtask
`endif

    task automatic test_random();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            startGame     = ($urandom_range(0, 9) == 0);
            player_scored = ($urandom_range(0, 1) == 1);
            timer_expired = ($urandom_range(0, 19) == 0);
            tick();
            n_checks++;
            if (game_active !== (m_phase == P_PLAY) || score !== 6'(m_score)) begin
                $display("FAIL random_%0d: got active=%b score=%0d want %b/%0d", i, game_active, score, (m_phase == P_PLAY), m_score);
                n_fail++;
            end
        end
        reset = 1'b0; startGame = 1'b0; player_scored = 1'b0; timer_expired = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_score();
        test_expiry();
        test_saturation_collision();
        test_reset_mid_round();
`ifdef GAME_FSM_INTERNAL_TIMER_EN
        test_internal_timer();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_fsm_ctrl.md
# game_fsm_ctrl

Top-level game controller for the FPGA game. It sequences the game through idle, active and over phases and accumulates the player's score while a round is active. It sits between the input conditioning logic (start button, score detector, game timer) and the display and scoring logic, all in the 100 MHz `clkIn` domain.

## Interface

- `game_timer`, default 30: round length in `incrementClk` rising edges, used only when `GAME_FSM_INTERNAL_TIMER_EN` is defined; legal range is 1..1023.

- `clkIn`  input  1  100 MHz system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `incrementClk`  input  1  slow game tick (1 Hz on hardware), asynchronous to `clkIn`.
- `startGame`  input  1  start or restart request, sampled every `clkIn` cycle.
- `player_scored`  input  1  score event; a rising edge counts as one point.
- `timer_expired`  input  1  external end-of-round request, level sampled.
- `game_active`  output  1  registered; 1 only in ACTIVE.
- `score`  output  6  registered; points scored in the current or most recent round.

## Operation

- States are IDLE, ACTIVE and OVER, held in a 2-bit encoding.
- Reset (`reset`=1 at a clock edge) forces IDLE, `score`=0, `game_active`=0, all edge-detect and countdown registers to 0. This applies in any state, including mid-round.
- From IDLE:
  - `startGame`=1 moves to ACTIVE and clears `score` to 0.
  - All other inputs are ignored.
- In ACTIVE:
  - A rising edge on `player_scored` increments `score` by 1. This means the previous sample was 0 and the current sample is 1.
  - A level held high counts once.
  - `score` saturates at 63 and never wraps.
- In ACTIVE, `timer_expired`=1 moves to OVER. If `GAME_FSM_INTERNAL_TIMER_EN` is defined, the internal countdown reaching zero also moves to OVER.
- In ACTIVE, `startGame` is ignored.
- If expiry and a score edge occur in the same cycle, expiry wins: the state becomes OVER and `score` is not incremented.
- In OVER:
  - `score` holds its final value.
  - `player_scored` and `timer_expired` are ignored.
  - `startGame`=1 moves to ACTIVE and clears `score` to 0.
- The `player_scored` edge register updates every cycle in every state. A level already high on entry to ACTIVE does not score.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- Start latency: `startGame` sampled high at edge N gives `game_active`=1 and `score`=0 after edge N.
- Score latency: the first high sample of `player_scored` at edge N gives `score`+1 after edge N.
- A 1-cycle (10 ns) pulse on any input is sufficient.
- Expiry latency: `timer_expired` sampled high at edge N gives `game_active`=0 after edge N.
- `incrementClk` passes through a 2-flop synchronizer and then a rising-edge detector. This produces a 1-cycle tick 3 `clkIn` edges after the input rises.

## Configuration

- Macro `GAME_FSM_INTERNAL_TIMER_EN`.
- Defined:
  - A down-counter of width clog2(`game_timer`+1) loads `game_timer` on every entry to ACTIVE.
  - The counter decrements once per `incrementClk` tick while in ACTIVE.
  - The tick that takes it from 1 to 0 moves the FSM to OVER, in the same cycle as that tick.
  - `timer_expired` still ends the round early.
- Not defined:
  - No synchronizer and no counter are built.
  - `incrementClk` and `game_timer` are unused.
  - Only `timer_expired` ends a round.

## Structure

- Shared package `game_fsm_pkg` holds:
  - the state encoding constants `ST_IDLE`=0, `ST_ACTIVE`=1, `ST_OVER`=2 (encoding 3 is illegal and recovers to IDLE on the next edge);
  - `SCORE_W`=6;
  - `SCORE_MAX`=63.
- One sub-module, `sync_edge_detect`, provides an optional 2-flop synchronizer plus a rising-edge detector.
  - It is reused for `player_scored` (without synchronizer) and `incrementClk` (with synchronizer).

## Test plan

- Reset: hold `reset`=1 for 2 cycles, then release, with all inputs at 0 → IDLE, `game_active`=0, `score`=0. Pulse `player_scored` → `score` stays 0.
- Start and score: pulse `startGame` for 1 cycle → `game_active`=1 next cycle. Two 1-cycle `player_scored` pulses 100 ns apart → `score`=2. Holding `player_scored` high for 5 cycles adds only 1.
- Expiry: from ACTIVE with `score`=2, pulse `timer_expired` → `game_active`=0 and `score` holds 2. A further `player_scored` pulse leaves `score`=2. Pulse `startGame` → ACTIVE with `score`=0.
- Saturation and collision:
  - 70 `player_scored` edges → `score`=63.
  - `timer_expired` and a `player_scored` edge in the same cycle → OVER with `score` unchanged.
- Internal timer (macro defined, `game_timer`=3, `incrementClk` period 200 ns): start the game → `game_active` falls 3 cycles after the third `incrementClk` rising edge following the start.
- Reset mid-round: assert `reset` while ACTIVE with `score`=5 → next cycle IDLE, `score`=0, `game_active`=0.
